// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Purpose  : Byte-addressed, row-banked data memory with a req/ready
//            handshake, per-byte write enables and unaligned accesses.
//            An access that crosses a row boundary takes two row cycles.
//            Optionally zeroes every row after reset, one row per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    ready,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   data_out
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);
  localparam int RW   = ADDR_WIDTH - OFFW;
  localparam int ROWS = 2 ** RW;

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_SECOND = 2'd2
  } state_e;

  localparam state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  // Control / latched-request registers
  state_e                state_q, state_d;
  logic [RW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  ready_q, ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [RW-1:0]         lat_row_q, lat_row_d;
  logic [OFFW-1:0]       lat_off_q, lat_off_d;
  logic                  lat_we_q, lat_we_d;
  logic [DATA_WIDTH-1:0] lat_data_q, lat_data_d;
  logic [NB-1:0]         lat_be_q, lat_be_d;
  logic [DATA_WIDTH-1:0] rd_buf_q, rd_buf_d;

  // Storage array
  logic [DATA_WIDTH-1:0] mem_q [ROWS];

  // Row-access selection
  logic                  w_clear;
  logic                  w_acc;
  logic [RW-1:0]         w_row;
  logic [OFFW-1:0]       w_off;
  logic                  w_first;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_wsrc;
  logic [NB-1:0]         w_besrc;

  // Lane steering
  logic [DATA_WIDTH-1:0] w_rd_row;
  logic [NB-1:0]         w_lane_we;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_asm;
  logic [7:0]            w_wsrc_b   [NB];
  logic [7:0]            w_first_b  [NB];
  logic [7:0]            w_row_b    [NB];
  logic [OFFW-1:0]       w_src_lane [NB];
  logic [OFFW:0]         w_rd_lane  [NB];

  assign ready      = ready_q;
  assign resp_valid = resp_valid_q;
  assign data_out   = data_out_q;
  assign w_rd_row   = mem_q[w_row];

  // Pick which row is touched this cycle, with which offset and which source
  always_comb begin
    w_clear = 1'b0;
    w_acc   = 1'b0;
    w_row   = lat_row_q + 1'b1;
    w_off   = lat_off_q;
    w_first = 1'b0;
    w_write = lat_we_q;
    w_wsrc  = lat_data_q;
    w_besrc = lat_be_q;
    case (state_q)
      S_CLEAR: begin
        w_clear = 1'b1;
        w_row   = clr_cnt_q;
      end
      S_IDLE: begin
        w_row   = addr[ADDR_WIDTH-1:OFFW];
        w_off   = addr[OFFW-1:0];
        w_first = 1'b1;
        w_write = we;
        w_wsrc  = data_in;
        w_besrc = byte_en;
        w_acc   = req && ready_q;
      end
      S_SECOND: begin
        w_acc = 1'b1;
      end
      default: ;
    endcase
  end

  // Rotate write bytes into row lanes and gather read bytes into request order
  always_comb begin
    w_lane_we = '0;
    w_wdata   = '0;
    w_rd_asm  = '0;
    for (int l = 0; l < NB; l++) begin
      w_wsrc_b[l]   = w_wsrc[8*l +: 8];
      w_row_b[l]    = w_rd_row[8*l +: 8];
      w_first_b[l]  = w_first ? w_rd_row[8*l +: 8] : rd_buf_q[8*l +: 8];
      // Row lane l holds request byte (l - off) mod NB
      w_src_lane[l] = OFFW'(l) - w_off;
      // Request byte l sits at row-relative lane l + off (may spill to next row)
      w_rd_lane[l]  = {1'b0, OFFW'(l)} + {1'b0, w_off};
    end
    for (int l = 0; l < NB; l++) begin
      if (w_clear) begin
        w_lane_we[l] = 1'b1;
      end else if (w_acc && w_write && w_besrc[w_src_lane[l]] &&
                   ((OFFW'(l) >= w_off) == w_first)) begin
        w_lane_we[l] = 1'b1;
      end
      w_wdata[8*l +: 8] = w_clear ? 8'h00 : w_wsrc_b[w_src_lane[l]];
      if (!w_rd_lane[l][OFFW]) begin
        w_rd_asm[8*l +: 8] = w_first_b[w_rd_lane[l][OFFW-1:0]];
      end else begin
        w_rd_asm[8*l +: 8] = w_row_b[w_rd_lane[l][OFFW-1:0]];
      end
    end
  end

  // FSM next state, request latching and response generation
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    resp_valid_d = 1'b0;
    data_out_d   = data_out_q;
    lat_row_d    = lat_row_q;
    lat_off_d    = lat_off_q;
    lat_we_d     = lat_we_q;
    lat_data_d   = lat_data_q;
    lat_be_d     = lat_be_q;
    rd_buf_d     = rd_buf_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == RW'(ROWS - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (w_acc) begin
          if (w_off == '0) begin
            if (!we) begin
              data_out_d   = w_rd_asm;
              resp_valid_d = 1'b1;
            end
          end else begin
            lat_row_d  = w_row;
            lat_off_d  = w_off;
            lat_we_d   = we;
            lat_data_d = data_in;
            lat_be_d   = byte_en;
            rd_buf_d   = w_rd_row;
            state_d    = S_SECOND;
          end
        end
      end
      S_SECOND: begin
        if (!lat_we_q) begin
          data_out_d   = w_rd_asm;
          resp_valid_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = RESET_STATE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // Control registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RESET_STATE;
      clr_cnt_q    <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      data_out_q   <= '0;
      lat_row_q    <= '0;
      lat_off_q    <= '0;
      lat_we_q     <= 1'b0;
      lat_data_q   <= '0;
      lat_be_q     <= '0;
      rd_buf_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      data_out_q   <= data_out_d;
      lat_row_q    <= lat_row_d;
      lat_off_q    <= lat_off_d;
      lat_we_q     <= lat_we_d;
      lat_data_q   <= lat_data_d;
      lat_be_q     <= lat_be_d;
      rd_buf_q     <= rd_buf_d;
    end
  end

  // Storage write port, one byte lane enable per lane, no reset on the array
  always_ff @(posedge clk) begin
    for (int l = 0; l < NB; l++) begin
      if (w_lane_we[l]) mem_q[w_row][8*l +: 8] <= w_wdata[8*l +: 8];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Purpose  : Directed, table-driven checks of data_memory with 16 bytes /
//            8 rows: clear, aligned and split accesses, byte enables,
//            wrap-around, back-to-back traffic and reset during a split.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] data_in = '0;
  logic [1:0]  byte_en = '0;
  logic        ready;
  logic        resp_valid;
  logic [15:0] data_out;

  int n_vec = 0;
  int n_err = 0;

  vec_t tbl [14];

  data_memory #(
    .ADDR_WIDTH    (4),
    .DATA_WIDTH    (16),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .data_in   (data_in),
    .byte_en   (byte_en),
    .ready     (ready),
    .resp_valid(resp_valid),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    @(negedge clk);
    for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
    chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  // Called at a negedge right after rst_n rises; counts edges until ready
  task automatic run_clear();
    int cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ready === 1'b1) break;
    end
    chk("clear_cycles", cnt, 8);
  endtask

  task automatic apply(input vec_t v);
    logic split;
    split = v.addr[0];
    wait_ready();
    req = 1'b1; we = v.we; addr = v.addr; data_in = v.wdata; byte_en = v.be;
    @(posedge clk);
    #1;
    if (split) begin
      // Junk during the second row cycle must not be taken
      req = 1'b1; we = 1'b1; addr = 4'h8; data_in = 16'hFFFF; byte_en = 2'b11;
    end else begin
      req = 1'b0;
    end
    chk($sformatf("ready_after_accept a=%0d", v.addr), {31'd0, ready}, {31'd0, !split});
    chk($sformatf("resp_first a=%0d", v.addr), {31'd0, resp_valid}, {31'd0, (!v.we && !split)});
    if (!split && !v.we) chk($sformatf("rdata a=%0d", v.addr), {16'd0, data_out}, {16'd0, v.exp});
    if (split) begin
      @(posedge clk);
      #1;
      req = 1'b0;
      chk($sformatf("resp_second a=%0d", v.addr), {31'd0, resp_valid}, {31'd0, !v.we});
      chk($sformatf("ready_after_second a=%0d", v.addr), {31'd0, ready}, 32'd1);
      if (!v.we) chk($sformatf("rdata_split a=%0d", v.addr), {16'd0, data_out}, {16'd0, v.exp});
    end
  endtask

  initial begin
    vec_t rv;
    logic [15:0] bb_data [3];
    bb_data[0] = 16'h1111; bb_data[1] = 16'h2222; bb_data[2] = 16'h4444;

    //            we    addr   wdata     be     expected read
    tbl[0]  = '{1'b1, 4'd4,  16'hBEEF, 2'b11, 16'h0000};
    tbl[1]  = '{1'b0, 4'd4,  16'h0000, 2'b00, 16'hBEEF};
    tbl[2]  = '{1'b0, 4'd5,  16'h0000, 2'b00, 16'h00BE};
    tbl[3]  = '{1'b1, 4'd2,  16'h1234, 2'b01, 16'h0000};
    tbl[4]  = '{1'b0, 4'd2,  16'h0000, 2'b00, 16'h0034};
    tbl[5]  = '{1'b1, 4'd15, 16'hA55A, 2'b11, 16'h0000};
    tbl[6]  = '{1'b0, 4'd14, 16'h0000, 2'b00, 16'h5A00};
    tbl[7]  = '{1'b0, 4'd0,  16'h0000, 2'b00, 16'h00A5};
    tbl[8]  = '{1'b0, 4'd15, 16'h0000, 2'b00, 16'hA55A};
    tbl[9]  = '{1'b1, 4'd3,  16'h7766, 2'b10, 16'h0000};
    tbl[10] = '{1'b0, 4'd3,  16'h0000, 2'b00, 16'h7700};
    tbl[11] = '{1'b1, 4'd5,  16'hFFFF, 2'b00, 16'h0000};
    tbl[12] = '{1'b0, 4'd4,  16'h0000, 2'b00, 16'hBE77};
    tbl[13] = '{1'b0, 4'd1,  16'h0000, 2'b00, 16'h3400};

    // Reset values and initial clear
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("rst_data", {16'd0, data_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear();
    rv = '{1'b0, 4'd0, 16'h0000, 2'b00, 16'h0000};
    apply(rv);

    // Table of single transactions
    for (int i = 0; i < 14; i++) apply(tbl[i]);

    // Back-to-back aligned writes then reads, ready held high
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; we = 1'b1; addr = 4'(2 * i); data_in = bb_data[i]; byte_en = 2'b11;
      @(posedge clk);
      #1;
      chk($sformatf("b2b_wr_ready %0d", i), {31'd0, ready}, 32'd1);
      chk($sformatf("b2b_wr_resp %0d", i), {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; we = 1'b0; addr = 4'(2 * i);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_rd_ready %0d", i), {31'd0, ready}, 32'd1);
      chk($sformatf("b2b_rd_resp %0d", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("b2b_rd_data %0d", i), {16'd0, data_out}, {16'd0, bb_data[i]});
      @(negedge clk);
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_resp_drop", {31'd0, resp_valid}, 32'd0);
    chk("b2b_data_hold", {16'd0, data_out}, 32'h4444);

    // Reset asserted during the second cycle of a split read
    wait_ready();
    req = 1'b1; we = 1'b0; addr = 4'd1;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("split_in_second", {31'd0, ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_resp", {31'd0, resp_valid}, 32'd0);
    chk("midrst_data", {16'd0, data_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_resp_hold", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_clear();
    for (int i = 0; i < 4; i++) begin
      rv = '{1'b0, 4'(i == 3 ? 15 : 2 * i), 16'h0000, 2'b00, 16'h0000};
      apply(rv);
    end
    rv = '{1'b0, 4'd1, 16'h0000, 2'b00, 16'h0000};
    apply(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
